// File: rtl/pipe_block_descrambler_if.sv
// PIPE RX beat bus into the descrambler and the registered descrambled beat out of it.
interface pipe_block_descrambler_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rx_valid;
  logic                  rx_start_block;
  logic [1:0]            rx_sync_header;
  logic [DATA_WIDTH-1:0] rx_data;

  logic                  out_valid;
  logic                  out_start_block;
  logic [1:0]            out_sync_header;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_os_type;
  logic                  out_sync_err;

  modport master (
    output rx_valid, rx_start_block, rx_sync_header, rx_data,
    input  out_valid, out_start_block, out_sync_header, out_data, out_os_type, out_sync_err
  );

  modport slave (
    input  rx_valid, rx_start_block, rx_sync_header, rx_data,
    output out_valid, out_start_block, out_sync_header, out_data, out_os_type, out_sync_err
  );
endinterface

// File: rtl/pipe_block_descrambler.sv
// Gen3 128b/130b one-lane RX descrambler: block tracking, SKP freeze, EIEOS reseed.
// Exactly one clock from rx_* to out_*; no backpressure, every valid beat is consumed.
module pipe_block_descrambler #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [22:0] LANE_SEED  = 23'h1DBFBC
) (
  input  logic clk,
  input  logic reset,
  input  logic bypass,
  input  logic lfsr_reset_req,
  pipe_block_descrambler_if.slave bus
);
  localparam int          BYTES     = DATA_WIDTH / 8;
  localparam logic [22:0] TAPS      = 23'h210125;
  localparam logic [4:0]  BLK_BYTES = 5'd16;

  typedef enum logic [2:0] {BT_DATA, BT_SKP, BT_EIEOS, BT_OS, BT_BAD} blk_t;

  logic [22:0]           lfsr_q, lfsr_d, lfsr_adv;
  logic [3:0]            cnt_q, cnt_d;
  blk_t                  typ_q, typ_d, cur_typ;
  logic [1:0]            hdr_q, hdr_d, cur_hdr;
  logic                  need_start_q, need_start_d;
  logic [DATA_WIDTH-1:0] ks, dsc_data;
  logic                  misplaced, missing, hdr_bad;
  logic [3:0]            pos;
  logic [4:0]            end_pos;
  logic [1:0]            cur_os;

  logic                  out_valid_q, out_start_q, out_err_q;
  logic [1:0]            out_hdr_q, out_os_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  // Bit i of byte k is the LFSR MSB after k*8+i Galois steps; lfsr_adv is the state after the beat.
  always_comb begin
    lfsr_adv = lfsr_q;
    ks       = '0;
    for (int n = 0; n < DATA_WIDTH; n++) begin
      ks[n]    = lfsr_adv[22];
      lfsr_adv = {lfsr_adv[21:0], 1'b0} ^ (lfsr_adv[22] ? TAPS : 23'h0);
    end
  end

  always_comb begin
    misplaced = bus.rx_start_block && (cnt_q != 4'd0) && !need_start_q;
    missing   = !bus.rx_start_block && ((cnt_q == 4'd0) || need_start_q);
    hdr_bad   = bus.rx_start_block &&
                ((bus.rx_sync_header == 2'b00) || (bus.rx_sync_header == 2'b11));
    pos       = bus.rx_start_block ? 4'd0 : cnt_q;
    end_pos   = {1'b0, pos} + 5'(BYTES);
    cur_hdr   = bus.rx_start_block ? bus.rx_sync_header : hdr_q;

    cur_typ = typ_q;
    if (bus.rx_start_block) begin
      if (hdr_bad)                           cur_typ = BT_BAD;
      else if (bus.rx_sync_header == 2'b10)  cur_typ = BT_DATA;
      else if (bus.rx_data[7:0] == 8'hAA)    cur_typ = BT_SKP;
      else if (bus.rx_data[7:0] == 8'h00)    cur_typ = BT_EIEOS;
      else                                   cur_typ = BT_OS;
    end

    case (cur_typ)
      BT_DATA:  cur_os = 2'd0;
      BT_SKP:   cur_os = 2'd1;
      BT_EIEOS: cur_os = 2'd2;
      default:  cur_os = 2'd3;
    endcase

    // Ordered-set byte 0 (the type byte) is sent in the clear.
    dsc_data = bus.rx_data;
    for (int k = 0; k < BYTES; k++) begin
      if ((cur_typ == BT_DATA) || ((cur_typ == BT_OS) && ((pos + 4'(k)) != 4'd0))) begin
        dsc_data[k*8 +: 8] = bus.rx_data[k*8 +: 8] ^ ks[k*8 +: 8];
      end
    end
  end

  always_comb begin
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    typ_d        = typ_q;
    hdr_d        = hdr_q;
    need_start_d = need_start_q;
    if (bypass) begin
      need_start_d = 1'b1;
    end else if (bus.rx_valid) begin
      cnt_d        = end_pos[3:0];
      typ_d        = cur_typ;
      hdr_d        = cur_hdr;
      need_start_d = 1'b0;
      if ((cur_typ == BT_EIEOS) && (end_pos == BLK_BYTES)) lfsr_d = LANE_SEED;
      else if (cur_typ != BT_SKP)                          lfsr_d = lfsr_adv;
    end
    if (lfsr_reset_req) lfsr_d = LANE_SEED;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q       <= LANE_SEED;
      cnt_q        <= 4'd0;
      typ_q        <= BT_DATA;
      hdr_q        <= 2'b00;
      need_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_start_q  <= 1'b0;
      out_hdr_q    <= 2'b00;
      out_data_q   <= '0;
      out_os_q     <= 2'd0;
      out_err_q    <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      typ_q        <= typ_d;
      hdr_q        <= hdr_d;
      need_start_q <= need_start_d;
      out_valid_q  <= bus.rx_valid;
      if (bypass) begin
        out_start_q <= bus.rx_valid & bus.rx_start_block;
        out_hdr_q   <= bus.rx_sync_header;
        out_data_q  <= bus.rx_data;
        out_os_q    <= 2'd0;
        out_err_q   <= 1'b0;
      end else if (bus.rx_valid) begin
        out_start_q <= bus.rx_start_block;
        out_hdr_q   <= cur_hdr;
        out_data_q  <= dsc_data;
        out_os_q    <= cur_os;
        out_err_q   <= misplaced | missing | hdr_bad;
      end else begin
        out_start_q <= 1'b0;
        out_err_q   <= 1'b0;
      end
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_start_block = out_start_q;
  assign bus.out_sync_header = out_hdr_q;
  assign bus.out_data        = out_data_q;
  assign bus.out_os_type     = out_os_q;
  assign bus.out_sync_err    = out_err_q;
endmodule

// File: tb/tb_pipe_block_descrambler.sv
// Bench for pipe_block_descrambler at 8/16/32-bit widths against a keystream-table reference.
module tb_pipe_block_descrambler;
  localparam logic [22:0] SEED = 23'h1DBFBC;

  logic clk = 1'b0;
  logic reset, bypass, lfsr_reset_req;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] kst [256];

  always #5 clk = ~clk;

  pipe_block_descrambler_if #(.DATA_WIDTH(8))  if8  ();
  pipe_block_descrambler_if #(.DATA_WIDTH(16)) if16 ();
  pipe_block_descrambler_if #(.DATA_WIDTH(32)) if32 ();

  pipe_block_descrambler #(.DATA_WIDTH(8),  .LANE_SEED(SEED)) dut8 (
    .clk(clk), .reset(reset), .bypass(bypass), .lfsr_reset_req(lfsr_reset_req), .bus(if8));
  pipe_block_descrambler #(.DATA_WIDTH(16), .LANE_SEED(SEED)) dut16 (
    .clk(clk), .reset(reset), .bypass(bypass), .lfsr_reset_req(lfsr_reset_req), .bus(if16));
  pipe_block_descrambler #(.DATA_WIDTH(32), .LANE_SEED(SEED)) dut32 (
    .clk(clk), .reset(reset), .bypass(bypass), .lfsr_reset_req(lfsr_reset_req), .bus(if32));

  typedef struct {
    logic        vld;
    logic        sb;
    logic [1:0]  hdr;
    logic [31:0] dat;
    logic [31:0] edat;
    logic [1:0]  etyp;
    logic        eerr;
  } vec_t;
  vec_t tbl[$];

  // Keystream bit n = coefficient of x^22 in seed * x^n mod P(x).
  task automatic gen_ks();
    logic [23:0] s;
    s = {1'b0, SEED};
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 8; i++) begin
        kst[n][i] = s[22];
        s = s << 1;
        if (s[23]) s = s ^ 24'hA10125;
      end
    end
  endtask

  function automatic logic [31:0] kw(input int n);
    return {kst[n+3], kst[n+2], kst[n+1], kst[n]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic vld, input logic sb,
                       input logic [1:0] hdr, input logic [31:0] dat);
    if8.rx_valid  = 1'b0; if8.rx_start_block  = 1'b0; if8.rx_sync_header  = 2'b00; if8.rx_data  = '0;
    if16.rx_valid = 1'b0; if16.rx_start_block = 1'b0; if16.rx_sync_header = 2'b00; if16.rx_data = '0;
    if32.rx_valid = 1'b0; if32.rx_start_block = 1'b0; if32.rx_sync_header = 2'b00; if32.rx_data = '0;
    case (w)
      8:  begin if8.rx_valid = vld;  if8.rx_start_block = sb;  if8.rx_sync_header = hdr;  if8.rx_data = dat[7:0];   end
      16: begin if16.rx_valid = vld; if16.rx_start_block = sb; if16.rx_sync_header = hdr; if16.rx_data = dat[15:0]; end
      32: begin if32.rx_valid = vld; if32.rx_start_block = sb; if32.rx_sync_header = hdr; if32.rx_data = dat;       end
      default: ;
    endcase
  endtask

  task automatic sample(input int w, output logic v, output logic sb, output logic [1:0] hdr,
                        output logic [31:0] d, output logic [1:0] typ, output logic err);
    case (w)
      8: begin
        v = if8.out_valid; sb = if8.out_start_block; hdr = if8.out_sync_header;
        d = {24'h0, if8.out_data}; typ = if8.out_os_type; err = if8.out_sync_err;
      end
      16: begin
        v = if16.out_valid; sb = if16.out_start_block; hdr = if16.out_sync_header;
        d = {16'h0, if16.out_data}; typ = if16.out_os_type; err = if16.out_sync_err;
      end
      default: begin
        v = if32.out_valid; sb = if32.out_start_block; hdr = if32.out_sync_header;
        d = if32.out_data; typ = if32.out_os_type; err = if32.out_sync_err;
      end
    endcase
  endtask

  task automatic check_zero(input int w, input string tag);
    logic v, sb, err;
    logic [1:0] hdr, typ;
    logic [31:0] d;
    sample(w, v, sb, hdr, d, typ, err);
    chk($sformatf("%s w%0d ctrl", tag, w), {26'h0, v, sb, hdr, typ, err}, 32'h0);
    chk($sformatf("%s w%0d data", tag, w), d, 32'h0);
  endtask

  task automatic beat(input int w, input logic vld, input logic sb, input logic [1:0] hdr,
                      input logic [31:0] dat, input logic [31:0] edat, input logic [1:0] etyp,
                      input logic eerr, input string tag);
    logic v, osb, oerr;
    logic [1:0] ohdr, otyp;
    logic [31:0] od, mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    drive(w, vld, sb, hdr, dat);
    step();
    sample(w, v, osb, ohdr, od, otyp, oerr);
    chk({tag, " valid"}, v, vld);
    chk({tag, " sync_err"}, oerr, eerr);
    if (vld) begin
      chk({tag, " data"}, od, edat & mask);
      chk({tag, " os_type"}, otyp, etyp);
      chk({tag, " start"}, osb, sb);
      chk({tag, " hdr"}, ohdr, hdr);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0);
    step();
    reset = 1'b1;
  endtask

  task automatic add(input logic vld, input logic sb, input logic [1:0] hdr, input logic [31:0] dat,
                     input logic [31:0] edat, input logic [1:0] etyp, input logic eerr);
    vec_t v;
    v.vld = vld; v.sb = sb; v.hdr = hdr; v.dat = dat; v.edat = edat; v.etyp = etyp; v.eerr = eerr;
    tbl.push_back(v);
  endtask

  task automatic rand_run(input int w);
    logic [7:0]  orig [64];
    logic [31:0] d, e;
    int nb;
    nb = w / 8;
    do_reset();
    for (int i = 0; i < 64; i++) orig[i] = 8'($urandom);
    for (int p = 0; p < 64; p += nb) begin
      if ((p % 16 == 0) && ($urandom_range(0, 2) == 0)) begin
        for (int q = 0; q < 16; q += nb) begin
          d = $urandom;
          if (q == 0) d[7:0] = 8'hAA;
          beat(w, 1'b1, q == 0, 2'b01, d, d, 2'd1, 1'b0, $sformatf("rnd w%0d skp%0d", w, q));
        end
      end
      repeat ($urandom_range(0, 2)) beat(w, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, "rnd idle");
      d = 32'h0;
      e = 32'h0;
      for (int k = 0; k < nb; k++) begin
        d[k*8 +: 8] = orig[p+k] ^ kst[p+k];
        e[k*8 +: 8] = orig[p+k];
      end
      beat(w, 1'b1, (p % 16) == 0, 2'b10, d, e, 2'd0, 1'b0, $sformatf("rnd w%0d byte%0d", w, p));
    end
  endtask

  initial begin
    logic [31:0] skp_dat [4];
    skp_dat = '{32'h1234_56AA, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h55AA_00FF};
    reset = 1'b0;
    bypass = 1'b0;
    lfsr_reset_req = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0);
    gen_ks();
    step();
    step();
    check_zero(8, "reset");
    check_zero(16, "reset");
    check_zero(32, "reset");
    reset = 1'b1;

    // Block sequence at 32 bits; keystream offsets follow the LFSR across blocks.
    for (int j = 0; j < 4; j++) add(1, j == 0, 2'b10, 32'h0, kw(4*j), 2'd0, 0);
    for (int j = 0; j < 4; j++) add(1, j == 0, 2'b01, skp_dat[j], skp_dat[j], 2'd1, 0);
    for (int j = 0; j < 4; j++) add(1, j == 0, 2'b10, 32'h0, kw(16 + 4*j), 2'd0, 0);
    for (int j = 0; j < 4; j++) add(1, j == 0, 2'b01, 32'hFF00_FF00, 32'hFF00_FF00, 2'd2, 0);
    for (int j = 0; j < 4; j++) add(1, j == 0, 2'b10, 32'h0, kw(4*j), 2'd0, 0);
    for (int j = 0; j < 2; j++) add(1, j == 0, 2'b10, 32'h0, kw(16 + 4*j), 2'd0, 0);
    for (int j = 0; j < 4; j++) add(1, j == 0, 2'b10, 32'h0, kw(24 + 4*j), 2'd0, j == 0);
    for (int j = 0; j < 4; j++) add(1, j == 0, 2'b11, 32'hCAFE_F00D + j, 32'hCAFE_F00D + j, 2'd3, j == 0);
    for (int j = 0; j < 4; j++) add(1, j == 0, 2'b10, 32'h0, kw(56 + 4*j), 2'd0, 0);
    add(1, 1, 2'b01, 32'h0000_0055, (kw(72) & 32'hFFFF_FF00) | 32'h55, 2'd3, 0);
    for (int j = 1; j < 4; j++) add(1, 0, 2'b01, 32'h0, kw(72 + 4*j), 2'd3, 0);
    add(0, 0, 2'b00, 32'h0, 32'h0, 2'd0, 0);
    for (int j = 0; j < 4; j++) add(1, j == 0, 2'b10, 32'h0, kw(88 + 4*j), 2'd0, 0);
    for (int j = 0; j < 4; j++) add(1, 0, 2'b10, 32'h0, kw(104 + 4*j), 2'd0, j == 0);
    foreach (tbl[i])
      beat(32, tbl[i].vld, tbl[i].sb, tbl[i].hdr, tbl[i].dat, tbl[i].edat, tbl[i].etyp,
           tbl[i].eerr, $sformatf("vec%0d", i));

    // Reset mid-block, then a fresh block from the seed.
    do_reset();
    beat(32, 1, 1, 2'b10, 32'h0, kw(0), 2'd0, 0, "pre_rst0");
    beat(32, 1, 0, 2'b10, 32'h0, kw(4), 2'd0, 0, "pre_rst1");
    reset = 1'b0;
    drive(32, 1'b1, 1'b0, 2'b10, 32'h1234_5678);
    step();
    check_zero(32, "midrst");
    reset = 1'b1;
    for (int j = 0; j < 4; j++) beat(32, 1, j == 0, 2'b10, 32'h0, kw(4*j), 2'd0, 0, "post_rst");

    // lfsr_reset_req: current beat keeps the old state, seed from the next beat.
    lfsr_reset_req = 1'b1;
    beat(32, 1, 1, 2'b10, 32'h0, kw(16), 2'd0, 0, "req_beat");
    lfsr_reset_req = 1'b0;
    for (int j = 1; j < 4; j++) beat(32, 1, 0, 2'b10, 32'h0, kw(4*(j-1)), 2'd0, 0, "req_after");
    for (int j = 0; j < 4; j++) begin
      lfsr_reset_req = (j == 3);
      beat(32, 1, j == 0, 2'b01, 32'hFF00_FF00, 32'hFF00_FF00, 2'd2, 0, "eieos_req");
    end
    lfsr_reset_req = 1'b0;
    for (int j = 0; j < 4; j++) beat(32, 1, j == 0, 2'b10, 32'h0, kw(4*j), 2'd0, 0, "post_eieos");

    // Bypass holds LFSR and counter; leaving it needs a block start.
    do_reset();
    for (int j = 0; j < 4; j++) beat(32, 1, j == 0, 2'b10, 32'h0, kw(4*j), 2'd0, 0, "pre_byp");
    bypass = 1'b1;
    beat(32, 1, 1, 2'b10, 32'hA5A5_0001, 32'hA5A5_0001, 2'd0, 0, "byp0");
    beat(32, 0, 0, 2'b00, 32'h0, 32'h0, 2'd0, 0, "byp_idle");
    beat(32, 1, 0, 2'b01, 32'h1234_0000, 32'h1234_0000, 2'd0, 0, "byp1");
    bypass = 1'b0;
    for (int j = 0; j < 4; j++) beat(32, 1, j == 0, 2'b10, 32'h0, kw(16 + 4*j), 2'd0, 0, "post_byp");
    bypass = 1'b1;
    beat(32, 1, 0, 2'b10, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 2'd0, 0, "byp2");
    bypass = 1'b0;
    beat(32, 1, 0, 2'b10, 32'h0, kw(32), 2'd0, 1, "byp_exit_nostart");

    rand_run(8);
    rand_run(16);
    rand_run(32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
